// File: rtl/neighbor_select_pkg.sv
// neighbor_select_pkg: shared constants and state encoding for neighbor_select.
package neighbor_select_pkg;

    localparam int unsigned NBSEL_DATA_W = 16;
    localparam int unsigned NBSEL_COST_W = 16;
    localparam int unsigned NBSEL_DEPTH  = 16;
    localparam int unsigned NBSEL_IDX_W  = $clog2(NBSEL_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_REQ     = 3'd2,
        ST_WAIT    = 3'd3,
        ST_READ    = 3'd4,
        ST_OUT     = 3'd5
    } nbsel_state_e;

endpackage

// File: rtl/nbsel_buffer.sv
// nbsel_buffer: DEPTH x W register file, one write port, registered read port.
// Entry contents are not reset; only the read register is.
module nbsel_buffer
    import neighbor_select_pkg::*;
#(
    parameter int unsigned W     = NBSEL_DATA_W + NBSEL_COST_W,
    parameter int unsigned DEPTH = NBSEL_DEPTH,
    parameter int unsigned IDX_W = NBSEL_IDX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;
    logic [W-1:0] rdata_d;

    // Storage write
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read data holds until the next read enable
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Read register
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/neighbor_select.sv
// neighbor_select: buffers candidates cheaper than the current cost, then picks
// one through the rngAddress handshake and presents it to the search controller.
// Optional build macro NEIGHBOR_SELECT_GREEDY_EN: pick the cheapest buffered
// entry (earliest on ties) and skip the rngAddress handshake.
module neighbor_select
    import neighbor_select_pkg::*;
#(
    parameter int unsigned DATA_W = NBSEL_DATA_W,
    parameter int unsigned COST_W = NBSEL_COST_W,
    parameter int unsigned DEPTH  = NBSEL_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [COST_W-1:0] current_cost,
    input  logic              nb_valid,
    output logic              nb_ready,
    input  logic [DATA_W-1:0] nb_data,
    input  logic [COST_W-1:0] nb_cost,
    input  logic              nb_last,
    output logic              start_rng_address,
    output logic [15:0]       better_neighbor_count,
    input  logic [15:0]       rng_address_in,
    input  logic              done_rng_address,
    output logic              sel_valid,
    output logic [DATA_W-1:0] sel_data,
    output logic [COST_W-1:0] sel_cost,
    output logic              none_better,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = DATA_W + COST_W;

    nbsel_state_e      state_q, state_d;
    logic [COST_W-1:0] cur_cost_q, cur_cost_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              none_q, none_d;
    logic [IDX_W-1:0]  sel_idx_q, sel_idx_d;
`ifdef NEIGHBOR_SELECT_GREEDY_EN
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic [COST_W-1:0] best_cost_q, best_cost_d;
    logic              unused_rng;
    assign unused_rng = ^{rng_address_in, done_rng_address};
`endif

    logic              beat;
    logic              better;
    logic              room;
    logic [CNT_W-1:0]  count_m1;
    logic              buf_we;
    logic              buf_re;
    logic [ENT_W-1:0]  buf_rdata;

    nbsel_buffer #(
        .W     (ENT_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_buffer (
        .clock (clock),
        .reset (reset),
        .we    (buf_we),
        .waddr (count_q[IDX_W-1:0]),
        .wdata ({nb_data, nb_cost}),
        .re    (buf_re),
        .raddr (sel_idx_q),
        .rdata (buf_rdata)
    );

    assign beat     = nb_valid && (state_q == ST_COLLECT);
    assign better   = nb_cost < cur_cost_q;
    assign room     = count_q < CNT_W'(DEPTH);
    assign count_m1 = count_q - CNT_W'(1);

    // Next-state and iteration bookkeeping
    always_comb begin
        state_d    = state_q;
        cur_cost_d = cur_cost_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        none_d     = none_q;
        sel_idx_d  = sel_idx_q;
        buf_we     = 1'b0;
        buf_re     = 1'b0;
`ifdef NEIGHBOR_SELECT_GREEDY_EN
        best_idx_d  = best_idx_q;
        best_cost_d = best_cost_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_cost_d = current_cost;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    none_d     = 1'b0;
                    state_d    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (beat) begin
                    if (better) begin
                        if (room) begin
                            buf_we  = 1'b1;
                            count_d = count_q + CNT_W'(1);
`ifdef NEIGHBOR_SELECT_GREEDY_EN
                            if ((count_q == '0) || (nb_cost < best_cost_q)) begin
                                best_idx_d  = count_q[IDX_W-1:0];
                                best_cost_d = nb_cost;
                            end
`endif
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    // The last beat is counted above before deciding where to go.
                    if (nb_last) begin
                        if (count_d == '0) begin
                            none_d  = 1'b1;
                            state_d = ST_OUT;
                        end else begin
`ifdef NEIGHBOR_SELECT_GREEDY_EN
                            sel_idx_d = best_idx_d;
                            state_d   = ST_READ;
`else
                            state_d   = ST_REQ;
`endif
                        end
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rng_address) begin
                    if (rng_address_in < 16'(count_q)) begin
                        sel_idx_d = rng_address_in[IDX_W-1:0];
                    end else begin
                        sel_idx_d = count_m1[IDX_W-1:0];
                    end
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                buf_re  = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_cost_q <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            none_q     <= 1'b0;
            sel_idx_q  <= '0;
`ifdef NEIGHBOR_SELECT_GREEDY_EN
            best_idx_q  <= '0;
            best_cost_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cur_cost_q <= cur_cost_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            none_q     <= none_d;
            sel_idx_q  <= sel_idx_d;
`ifdef NEIGHBOR_SELECT_GREEDY_EN
            best_idx_q  <= best_idx_d;
            best_cost_q <= best_cost_d;
`endif
        end
    end

    assign nb_ready              = (state_q == ST_COLLECT);
    assign busy                  = (state_q != ST_IDLE);
    assign sel_valid             = (state_q == ST_OUT);
    assign better_neighbor_count = 16'(count_q);
    assign overflow              = overflow_q;
    assign none_better           = none_q;
`ifdef NEIGHBOR_SELECT_GREEDY_EN
    assign start_rng_address     = 1'b0;
`else
    assign start_rng_address     = (state_q == ST_REQ) || (state_q == ST_WAIT);
`endif
    // Buffer read register holds the pick; the no-better case overrides it.
    assign sel_data = none_q ? '0 : buf_rdata[ENT_W-1:COST_W];
    assign sel_cost = none_q ? cur_cost_q : buf_rdata[COST_W-1:0];

endmodule

// File: tb/tb_neighbor_select.sv
// tb_neighbor_select: directed vectors with hand-computed expectations.
// Build with NEIGHBOR_SELECT_GREEDY_EN to exercise the greedy variant.
module tb_neighbor_select;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] current_cost;
    logic        nb_valid;
    logic        nb_ready;
    logic [15:0] nb_data;
    logic [15:0] nb_cost;
    logic        nb_last;
    logic        start_rng_address;
    logic [15:0] better_neighbor_count;
    logic [15:0] rng_address_in;
    logic        done_rng_address;
    logic        sel_valid;
    logic [15:0] sel_data;
    logic [15:0] sel_cost;
    logic        none_better;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    neighbor_select #(
        .DATA_W (16),
        .COST_W (16),
        .DEPTH  (16)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .start                 (start),
        .current_cost          (current_cost),
        .nb_valid              (nb_valid),
        .nb_ready              (nb_ready),
        .nb_data               (nb_data),
        .nb_cost               (nb_cost),
        .nb_last               (nb_last),
        .start_rng_address     (start_rng_address),
        .better_neighbor_count (better_neighbor_count),
        .rng_address_in        (rng_address_in),
        .done_rng_address      (done_rng_address),
        .sel_valid             (sel_valid),
        .sel_data              (sel_data),
        .sel_cost              (sel_cost),
        .none_better           (none_better),
        .overflow              (overflow),
        .busy                  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_iter(input logic [15:0] cost);
        start        = 1'b1;
        current_cost = cost;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d, input logic [15:0] c, input logic last);
        nb_valid = 1'b1;
        nb_data  = d;
        nb_cost  = c;
        nb_last  = last;
        tick();
        nb_valid = 1'b0;
        nb_last  = 1'b0;
    endtask

    task automatic rng_reply(input logic [15:0] a);
        rng_address_in   = a;
        done_rng_address = 1'b1;
        tick();
        done_rng_address = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        current_cost     = '0;
        nb_valid         = 1'b0;
        nb_data          = '0;
        nb_cost          = '0;
        nb_last          = 1'b0;
        rng_address_in   = '0;
        done_rng_address = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(nb_ready), 32'd0);
        check("rst_rng", 32'(start_rng_address), 32'd0);
        check("rst_valid", 32'(sel_valid), 32'd0);
        check("rst_count", 32'(better_neighbor_count), 32'd0);
        check("rst_data", 32'(sel_data), 32'd0);
        check("rst_cost", 32'(sel_cost), 32'd0);

        // No better candidate: equal cost is not better
        begin_iter(16'd50);
        check("nb_ready_t1", 32'(nb_ready), 32'd1);
        beat(16'hB001, 16'd50, 1'b0);
        beat(16'hB002, 16'd60, 1'b1);
        check("nob_valid", 32'(sel_valid), 32'd1);
        check("nob_none", 32'(none_better), 32'd1);
        check("nob_cost", 32'(sel_cost), 32'd50);
        check("nob_data", 32'(sel_data), 32'd0);
        check("nob_rng", 32'(start_rng_address), 32'd0);
        tick();
        check("nob_valid_drop", 32'(sel_valid), 32'd0);
        check("nob_none_hold", 32'(none_better), 32'd1);

`ifdef NEIGHBOR_SELECT_GREEDY_EN
        // Greedy: cheapest, earliest on ties
        begin_iter(16'd100);
        beat(16'h9001, 16'd90, 1'b0);
        beat(16'h7001, 16'd70, 1'b0);
        check("gr_rng_a", 32'(start_rng_address), 32'd0);
        beat(16'h7002, 16'd70, 1'b0);
        beat(16'h9501, 16'd95, 1'b1);
        check("gr_rng_b", 32'(start_rng_address), 32'd0);
        check("gr_valid_early", 32'(sel_valid), 32'd0);
        check("gr_count", 32'(better_neighbor_count), 32'd4);
        tick();
        check("gr_valid", 32'(sel_valid), 32'd1);
        check("gr_data", 32'(sel_data), 32'h7001);
        check("gr_cost", 32'(sel_cost), 32'd70);
        check("gr_none", 32'(none_better), 32'd0);
        tick();
        check("gr_idle", 32'(busy), 32'd0);
`else
        // Basic random pick
        begin_iter(16'd100);
        beat(16'hA001, 16'd120, 1'b0);
        beat(16'hA002, 16'd90, 1'b0);
        beat(16'hA003, 16'd80, 1'b0);
        beat(16'hA004, 16'd150, 1'b1);
        check("bas_rng_req", 32'(start_rng_address), 32'd1);
        check("bas_count", 32'(better_neighbor_count), 32'd2);
        tick();
        check("bas_rng_wait", 32'(start_rng_address), 32'd1);
        check("bas_count_wait", 32'(better_neighbor_count), 32'd2);
        rng_reply(16'd1);
        check("bas_rng_drop", 32'(start_rng_address), 32'd0);
        check("bas_valid_read", 32'(sel_valid), 32'd0);
        tick();
        check("bas_valid", 32'(sel_valid), 32'd1);
        check("bas_data", 32'(sel_data), 32'hA003);
        check("bas_cost", 32'(sel_cost), 32'd80);
        check("bas_none", 32'(none_better), 32'd0);
        tick();
        check("bas_valid_drop", 32'(sel_valid), 32'd0);
        check("bas_cost_hold", 32'(sel_cost), 32'd80);
        check("bas_idle", 32'(busy), 32'd0);

        // Overflow: 20 better candidates, first 16 kept; read both ends
        for (int p = 0; p < 2; p++) begin
            begin_iter(16'd100);
            for (int i = 0; i < 20; i++) begin
                beat(16'hC000 + 16'(i), 16'd10, i == 19);
            end
            check("ovf_count", 32'(better_neighbor_count), 32'd16);
            check("ovf_flag", 32'(overflow), 32'd1);
            check("ovf_rng", 32'(start_rng_address), 32'd1);
            tick();
            rng_reply((p == 0) ? 16'd15 : 16'd0);
            tick();
            check("ovf_valid", 32'(sel_valid), 32'd1);
            check("ovf_data", 32'(sel_data), (p == 0) ? 32'hC00F : 32'hC000);
            check("ovf_cost", 32'(sel_cost), 32'd10);
            tick();
        end

        // Clamp out-of-range address
        begin_iter(16'd100);
        beat(16'hD001, 16'd90, 1'b0);
        check("clp_ovf_clr", 32'(overflow), 32'd0);
        beat(16'hD002, 16'd95, 1'b1);
        tick();
        rng_reply(16'd13);
        tick();
        check("clp_valid", 32'(sel_valid), 32'd1);
        check("clp_data", 32'(sel_data), 32'hD002);
        check("clp_cost", 32'(sel_cost), 32'd95);
        tick();

        // Reset during WAIT
        begin_iter(16'd100);
        beat(16'hE001, 16'd10, 1'b1);
        tick();
        check("rw_rng_wait", 32'(start_rng_address), 32'd1);
        reset            = 1'b1;
        done_rng_address = 1'b1;
        tick();
        reset            = 1'b0;
        done_rng_address = 1'b0;
        check("rw_rng", 32'(start_rng_address), 32'd0);
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_count", 32'(better_neighbor_count), 32'd0);
        check("rw_data", 32'(sel_data), 32'd0);
        check("rw_cost", 32'(sel_cost), 32'd0);
        check("rw_none", 32'(none_better), 32'd0);
        tick();
        check("rw_no_valid", 32'(sel_valid), 32'd0);
        begin_iter(16'd40);
        beat(16'hF001, 16'd30, 1'b1);
        check("rw2_count", 32'(better_neighbor_count), 32'd1);
        tick();
        rng_reply(16'd0);
        tick();
        check("rw2_valid", 32'(sel_valid), 32'd1);
        check("rw2_data", 32'(sel_data), 32'hF001);
        check("rw2_cost", 32'(sel_cost), 32'd30);
        check("rw2_ovf", 32'(overflow), 32'd0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neighbor_select.md
# neighbor_select

Collects candidate neighbours from the neighbour generator in each search iteration. Keeps those whose cost is strictly below the current cost in a small buffer and reports the count to `rngAddress` as `betterNeighborCount`. Drives the `start_rng_address`/`done_rng_address` handshake from the initiator side, then reads the buffer at the returned `rng_address_out` and presents the chosen neighbour to the search controller.

## Interface
- `DATA_W`, 16: neighbour solution word width
- `COST_W`, 16: cost width, unsigned
- `DEPTH`, 16: buffer entries; matches the 4-bit RNG range
- `clock` in 1: rising-edge clock
- `reset` in 1: reset is synchronous and active-high; one clock
- `start` in 1: begin an iteration; sampled only in IDLE
- `current_cost` in COST_W: latched on accepted `start`
- `nb_valid` in 1: candidate beat valid
- `nb_ready` out 1: high only in COLLECT
- `nb_data` in DATA_W: candidate solution
- `nb_cost` in COST_W: candidate cost
- `nb_last` in 1: final candidate of the iteration
- `start_rng_address` out 1: request to `rngAddress`
- `better_neighbor_count` out 16: buffered count, zero-extended
- `rng_address_in` in 16: `rngAddress` result
- `done_rng_address` in 1: `rngAddress` completion
- `sel_valid` out 1: one-cycle result strobe
- `sel_data` out DATA_W: chosen neighbour
- `sel_cost` out COST_W: chosen cost
- `none_better` out 1: no candidate beat `current_cost`
- `overflow` out 1: more than DEPTH better candidates were seen
- `busy` out 1: state is not IDLE

## Operation
- States: IDLE, COLLECT, REQ, WAIT, READ, OUT.
- IDLE, on `start`:
  - latch `current_cost`
  - clear count, `overflow`, `none_better`
  - go to COLLECT
- COLLECT, on each `nb_valid & nb_ready` beat:
  - if `nb_cost < current_cost` and count < DEPTH: write {data, cost} at index count, count++
  - if better and count == DEPTH: drop the beat and set `overflow`
  - equal cost is not better
- COLLECT, on a `nb_last` beat:
  - that beat is evaluated first
  - then go to OUT with `none_better=1` if count==0, else go to REQ
- REQ/WAIT:
  - `start_rng_address` is high from REQ entry until the cycle `done_rng_address` is sampled high in WAIT
  - `better_neighbor_count` is stable throughout
- Address use: on `done_rng_address`, latch index = `rng_address_in` if it is < count, else count-1 (clamp).
- READ: registered buffer read.
- OUT:
  - `sel_valid` is high for one cycle; return to IDLE
  - `sel_data`, `sel_cost`, `none_better`, `overflow` hold until the next accepted `start`
  - when `none_better`=1: `sel_data`=0, `sel_cost`=`current_cost`
- Ignored inputs:
  - `start` outside IDLE
  - `done_rng_address` outside WAIT
  - `nb_valid` outside COLLECT

## Timing
- Reset value of all outputs and state: 0, state IDLE, count 0. Reset wins over any simultaneous input.
- Reset mid-operation aborts the iteration and drops `start_rng_address` the next cycle. No `sel_valid` is produced.
- `start` in cycle T → `nb_ready` high in T+1.
- COLLECT accepts one beat per cycle, with no bubbles.
- `nb_last` accepted in T → `start_rng_address` high in T+1.
- `done_rng_address` sampled in W → `start_rng_address` low in W+1, READ in W+1, `sel_valid` in W+2.
- `nb_last` accepted with count==0 in T → `sel_valid` with `none_better` in T+1.
- Count saturates at DEPTH and never wraps.
- Buffer index width is clog2(DEPTH).

## Configuration
- `NEIGHBOR_SELECT_GREEDY_EN` defined:
  - COLLECT additionally tracks the index of the lowest-cost buffered entry; on ties the earliest wins
  - REQ/WAIT are skipped: `nb_last` → READ of that index
  - `start_rng_address` is tied 0 and `rng_address_in`/`done_rng_address` are unused
  - `sel_valid` occurs two cycles after `nb_last`
- Undefined: random selection through `rngAddress` as above.

## Structure
- `neighbor_select_pkg`:
  - state encoding constants
  - default DATA_W/COST_W/DEPTH
  - `NBSEL_IDX_W` index-width constant
- One sub-module, `nbsel_buffer`:
  - DEPTH × (DATA_W+COST_W) register file
  - one write port, registered read port
  - no reset on contents

## Test plan
- Basic random pick: `current_cost`=100, candidate costs 120, 90, 80, 150 (150 with `nb_last`) → count 2, `better_neighbor_count`=2, `start_rng_address` high. Return `rng_address_in`=1 with `done_rng_address` → `sel_cost`=80 and its data, 2 cycles after done.
- No better candidate: `current_cost`=50, costs 50, 60 (`nb_last`) → no RNG request, `none_better`=1, `sel_cost`=50, `sel_valid` 1 cycle after `nb_last`.
- Overflow: 20 candidates all cost 10 vs `current_cost` 100 → count 16, `overflow`=1, entries 0–15 hold the first 16 candidates.
- Clamp: count 2, `rng_address_in`=13 → index 1 selected.
- Reset mid-handshake: reset asserted in WAIT → next cycle all outputs 0, `start_rng_address` 0. A following `start` runs a clean iteration.
- Greedy build (`NEIGHBOR_SELECT_GREEDY_EN`): costs 90, 70, 70, 95 vs 100 → first 70 selected, `start_rng_address` never asserted.
